// File: rtl/mips_cpu_alu_regs_if.sv
// Datapath bus between the multicycle bus controller (master) and the
// ALU/register-file core (slave).
interface mips_cpu_alu_regs_if;
  logic [3:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sa;
  logic [31:0] alu_r;
  logic        alu_zero;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] reg_data_in;
  logic [4:0]  reg_read_address_a;
  logic [31:0] reg_read_data_a;
  logic [4:0]  reg_read_address_b;
  logic [31:0] reg_read_data_b;
  logic [31:0] register_v0;

  modport master (
    output alu_control, alu_a, alu_b, alu_sa,
    output reg_write_enable, reg_write_address, reg_data_in,
    output reg_read_address_a, reg_read_address_b,
    input  alu_r, alu_zero, reg_read_data_a, reg_read_data_b, register_v0
  );

  modport slave (
    input  alu_control, alu_a, alu_b, alu_sa,
    input  reg_write_enable, reg_write_address, reg_data_in,
    input  reg_read_address_a, reg_read_address_b,
    output alu_r, alu_zero, reg_read_data_a, reg_read_data_b, register_v0
  );
endinterface

// File: rtl/mips_cpu_alu_regs.sv
// Multicycle MIPS datapath core: 32-bit ALU with registered result plus 32x32 register file.
// Optional macro REG_WRITE_BYPASS_EN forwards write data to same-address reads.
module mips_cpu_alu_regs (
  input  logic                 clk,
  input  logic                 reset,
  mips_cpu_alu_regs_if.slave   bus
);
  localparam logic [3:0] OP_NOP = 4'b1111;

  logic [31:0] alu_r_reg;
  logic        alu_zero_reg;
  logic [31:0] alu_next;
  logic [31:0] regs_reg [32];
  logic [4:0]  var_sa;

  assign var_sa = bus.alu_a[4:0];

  always_comb begin
    alu_next = alu_r_reg;
    case (bus.alu_control)
      4'b0000: alu_next = bus.alu_a & bus.alu_b;
      4'b0001: alu_next = bus.alu_a | bus.alu_b;
      4'b0010: alu_next = bus.alu_a ^ bus.alu_b;
      4'b0011: alu_next = ~(bus.alu_a | bus.alu_b);
      4'b0100: alu_next = bus.alu_a + bus.alu_b;
      4'b0101: alu_next = bus.alu_a - bus.alu_b;
      4'b0110: alu_next = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b0111: alu_next = {31'd0, bus.alu_a < bus.alu_b};
      4'b1000: alu_next = bus.alu_b << bus.alu_sa;
      4'b1001: alu_next = bus.alu_b >> bus.alu_sa;
      4'b1010: alu_next = $unsigned($signed(bus.alu_b) >>> bus.alu_sa);
      4'b1011: alu_next = bus.alu_b << var_sa;
      4'b1100: alu_next = bus.alu_b >> var_sa;
      4'b1101: alu_next = $unsigned($signed(bus.alu_b) >>> var_sa);
      4'b1110: alu_next = {bus.alu_b[15:0], 16'h0000};
      default: alu_next = alu_r_reg;
    endcase
  end

  // NOP leaves both the result and its zero flag untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_r_reg    <= '0;
      alu_zero_reg <= 1'b1;
    end else if (bus.alu_control != OP_NOP) begin
      alu_r_reg    <= alu_next;
      alu_zero_reg <= (alu_next == 32'd0);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // $0 is hardwired: writes to it are dropped
        always_ff @(posedge clk or posedge reset) begin
          regs_reg[gi] <= '0;
        end
      end else begin : g_gpr
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            regs_reg[gi] <= '0;
          end else if (bus.reg_write_enable && bus.reg_write_address == 5'(gi)) begin
            regs_reg[gi] <= bus.reg_data_in;
          end
        end
      end
    end
  endgenerate

`ifdef REG_WRITE_BYPASS_EN
  logic hit_a;
  logic hit_b;
  logic hit_v0;

  assign hit_a  = bus.reg_write_enable && (bus.reg_write_address != 5'd0) &&
                  (bus.reg_write_address == bus.reg_read_address_a);
  assign hit_b  = bus.reg_write_enable && (bus.reg_write_address != 5'd0) &&
                  (bus.reg_write_address == bus.reg_read_address_b);
  assign hit_v0 = bus.reg_write_enable && (bus.reg_write_address == 5'd2);

  assign bus.reg_read_data_a = hit_a  ? bus.reg_data_in : regs_reg[bus.reg_read_address_a];
  assign bus.reg_read_data_b = hit_b  ? bus.reg_data_in : regs_reg[bus.reg_read_address_b];
  assign bus.register_v0     = hit_v0 ? bus.reg_data_in : regs_reg[2];
`else
  assign bus.reg_read_data_a = regs_reg[bus.reg_read_address_a];
  assign bus.reg_read_data_b = regs_reg[bus.reg_read_address_b];
  assign bus.register_v0     = regs_reg[2];
`endif

  assign bus.alu_r    = alu_r_reg;
  assign bus.alu_zero = alu_zero_reg;
endmodule

// File: tb/tb_mips_cpu_alu_regs.sv
// Scoreboard bench for mips_cpu_alu_regs: stimulus pushes expectations, a monitor pops and compares.
module tb_mips_cpu_alu_regs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_alu_regs_if bus ();
  mips_cpu_alu_regs dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          cyc;
    bit          pre;
    int          sel;   // 0 alu_r, 1 alu_zero, 2 read a, 3 read b, 4 v0
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_alu;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sa);
    int          sa_i, sav_i;
    int signed   as, bs;
    logic [31:0] r;
    sa_i  = int'(sa);
    sav_i = int'(a % 32);
    as    = a;
    bs    = b;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = ~(a | b);
      4'd4:  r = a + b;
      4'd5:  r = a - b;
      4'd6:  r = (as < bs) ? 32'd1 : 32'd0;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = b << sa_i;
      4'd9:  r = b >> sa_i;
      4'd10: r = bs >>> sa_i;
      4'd11: r = b << sav_i;
      4'd12: r = b >> sav_i;
      4'd13: r = bs >>> sav_i;
      4'd14: r = (b & 32'hFFFF) * 32'h10000;
      default: r = m_alu;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] addr, input logic we,
                                           input logic [4:0] wa, input logic [31:0] din);
`ifdef REG_WRITE_BYPASS_EN
    if (we && wa != 5'd0 && wa == addr) return din;
`endif
    return m_regs[addr];
  endfunction

  task automatic push(input bit pre, input int c, input int sel, input logic [31:0] e,
                      input string n);
    exp_t it;
    it.cyc = c; it.pre = pre; it.sel = sel; it.exp = e; it.name = n;
    q.push_back(it);
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sa, input logic we, input logic [4:0] wa,
                      input logic [31:0] din, input logic [4:0] ra, input logic [4:0] rb,
                      input string n);
    @(negedge clk);
    bus.alu_control = op; bus.alu_a = a; bus.alu_b = b; bus.alu_sa = sa;
    bus.reg_write_enable = we; bus.reg_write_address = wa; bus.reg_data_in = din;
    bus.reg_read_address_a = ra; bus.reg_read_address_b = rb;
    push(1'b1, cyc, 2, ref_read(ra, we, wa, din), {n, ".rd_a_pre"});
    push(1'b1, cyc, 3, ref_read(rb, we, wa, din), {n, ".rd_b_pre"});
    push(1'b1, cyc, 4, ref_read(5'd2, we, wa, din), {n, ".v0_pre"});
    if (we && wa != 5'd0) m_regs[wa] = din;
    if (op != 4'hF) m_alu = ref_alu(op, a, b, sa);
    push(1'b0, cyc + 1, 0, m_alu, {n, ".alu_r"});
    push(1'b0, cyc + 1, 1, (m_alu == 32'd0) ? 32'd1 : 32'd0, {n, ".alu_zero"});
    push(1'b0, cyc + 1, 2, m_regs[ra], {n, ".rd_a_post"});
    push(1'b0, cyc + 1, 3, m_regs[rb], {n, ".rd_b_post"});
    push(1'b0, cyc + 1, 4, m_regs[2], {n, ".v0_post"});
  endtask

  // Raise reset between edges and expect cleared state before any clock edge
  task automatic reset_check(input logic [4:0] ra, input string n);
    @(negedge clk);
    bus.alu_control = 4'hF; bus.reg_write_enable = 1'b0;
    bus.reg_read_address_a = ra; bus.reg_read_address_b = ra;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_alu = '0;
    push(1'b1, cyc, 0, 32'd0, {n, ".alu_r"});
    push(1'b1, cyc, 1, 32'd1, {n, ".alu_zero"});
    push(1'b1, cyc, 2, 32'd0, {n, ".rd_a"});
    push(1'b1, cyc, 4, 32'd0, {n, ".v0"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return bus.alu_r;
      1: return {31'd0, bus.alu_zero};
      2: return bus.reg_read_data_a;
      3: return bus.reg_read_data_b;
      default: return bus.register_v0;
    endcase
  endfunction

  task automatic drain(input bit pre);
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && (q[0].cyc < cyc || (q[0].cyc == cyc && q[0].pre == pre))) begin
      e   = q.pop_front();
      act = actual(e.sel);
      tests++;
      if (e.cyc != cyc || act !== e.exp) begin
        fails++;
        $display("[TB] FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                 e.name, act, e.exp, cyc, e.cyc);
      end else begin
        $display("[TB] ok %s = %h", e.name, act);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #2; drain(1'b0);
      @(negedge clk); #2; drain(1'b1);
    end
  end

  initial begin
    logic [31:0] ra_v, rb_v;
    bus.alu_control = 4'hF; bus.alu_a = '0; bus.alu_b = '0; bus.alu_sa = '0;
    bus.reg_write_enable = 1'b0; bus.reg_write_address = '0; bus.reg_data_in = '0;
    bus.reg_read_address_a = '0; bus.reg_read_address_b = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_alu = '0;
    reset_check(5'd0, "por");

    step(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "add_wrap");
    step(4'd4, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "add_ovf");
    step(4'd10, 32'd0, 32'h8000_0000, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "sra");
    step(4'd9, 32'd0, 32'h8000_0000, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "srl");
    step(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "slt");
    step(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "sltu");
    step(4'd4, 32'd3, 32'd4, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "add7");
    step(4'hF, 32'd100, 32'd5, 5'd3, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "nop_hold");
    step(4'hF, 32'd0, 32'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, "wr_r0");
    step(4'hF, 32'd0, 32'd0, 5'd0, 1'b1, 5'd2, 32'hABCD, 5'd0, 5'd2, "wr_v0");
    step(4'hF, 32'd0, 32'd0, 5'd0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, "rdw_r3");
    step(4'hF, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, "rd_r3");
    step(4'd14, 32'd0, 32'h0000_BEEF, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, "wr_r5");
    reset_check(5'd5, "mid_reset");

    for (int i = 0; i < 150; i++) begin
      ra_v = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rb_v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(4'($urandom_range(0, 15)), ra_v, rb_v, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rand");
    end

    @(negedge clk);
    bus.alu_control = 4'hF; bus.reg_write_enable = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #5;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0 pending", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_cpu_alu_regs.md
# mips_cpu_alu_regs

Datapath core of the multicycle MIPS CPU: a 32-bit ALU with a registered result, plus the 32×32-bit general-purpose register file. The bus-controller FSM drives ALU operands and control in EXECUTE and consumes the result in WRITEBACK. It reads rs/rt through two combinational read ports and writes results back through one synchronous write port. `register_v0` exposes $2 for test observation.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `alu_control`  in  4  ALU operation select (encoding below).
- `alu_a`  in  32  operand A (rs value).
- `alu_b`  in  32  operand B (rt value or sign-extended immediate).
- `alu_sa`  in  5  shift amount for fixed shifts.
- `alu_r`  out  32  registered ALU result.
- `alu_zero`  out  1  registered flag, 1 when `alu_r` == 0.
- `reg_write_enable`  in  1  write strobe for register file.
- `reg_write_address`  in  5  destination register index.
- `reg_data_in`  in  32  write data.
- `reg_read_address_a`  in  5  read port A index.
- `reg_read_data_a`  out  32  read port A data (combinational).
- `reg_read_address_b`  in  5  read port B index.
- `reg_read_data_b`  out  32  read port B data (combinational).
- `register_v0`  out  32  current contents of $2.

## Operation
ALU `alu_control` encoding (result R; all arithmetic modulo 2^32; no overflow traps or flags):
- 0000 AND a&b.
- 0001 OR a|b.
- 0010 XOR a^b.
- 0011 NOR ~(a|b).
- 0100 ADD a+b (used for ADDU, ADDIU, LW/SW address).
- 0101 SUB a−b.
- 0110 SLT signed a<b → 1 else 0.
- 0111 SLTU unsigned a<b → 1 else 0.
- 1000 SLL b<<sa.
- 1001 SRL b>>sa, logical.
- 1010 SRA b>>>sa, arithmetic.
- 1011 SLLV b<<a[4:0].
- 1100 SRLV b>>a[4:0], logical.
- 1101 SRAV b>>>a[4:0], arithmetic.
- 1110 LUI {b[15:0],16'h0}.
- 1111 NOP: `alu_r` and `alu_zero` hold their previous values.

Register file:
- 32 registers of 32 bits; $0 reads as 0 at all times. A write to address 0 is discarded.
- Write: on posedge `clk` with `reg_write_enable`=1, reg[`reg_write_address`] <= `reg_data_in`.
- Reads: `reg_read_data_a/b` are purely combinational from the addresses and stored contents. Both ports may use the same address.
- `register_v0` = stored reg[2], combinational from storage.

## Timing
- Reset (async, level): all 32 registers, `alu_r` and `register_v0` go to 0 immediately; `alu_zero` goes to 1. Reset dominates any write or ALU op in the same cycle. Reset asserted mid-operation discards the pending result.
- ALU latency is 1 cycle. Operands and control sampled at posedge N; `alu_r`/`alu_zero` are valid after posedge N and stable until the next non-NOP edge.
- Register write latency is 1 cycle. The new value is visible on read ports and `register_v0` only after the write edge.
- Read during write to the same address returns the old value (no bypass) unless the macro below is defined.

## Configuration
- `REG_WRITE_BYPASS_EN` defined: when `reg_write_enable`=1 and a read address equals `reg_write_address` (≠0), that read port returns `reg_data_in` combinationally. `register_v0` also bypasses for address 2.
- Not defined: no forwarding; reads always reflect stored contents.

## Test plan
- Reset: write $5=0xDEADBEEF, assert `reset` mid-cycle. Required: `reg_read_data_a`(addr 5)=0 and `alu_r`=0 without waiting for a clock edge; `alu_zero`=1.
- ADD wrap: a=0xFFFFFFFF, b=1, control 0100. Required: one edge later `alu_r`=0 and `alu_zero`=1. Then a=0x7FFFFFFF, b=1 gives 0x80000000 with no trap.
- Shifts/compare: b=0x80000000, sa=4:
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
  - SLT a=−1, b=1 → 1.
  - SLTU a=−1, b=1 → 0.
- NOP hold: ADD produces 7, then control 1111 with new operands. Required: `alu_r` stays 7.
- $0 and v0: write 0x1234 to $0 and 0xABCD to $2. Required: reads of $0 return 0; `register_v0`=0xABCD after the edge, and still 0 before it.
- Read-during-write: write $3=0x55 while reading $3 on both ports. Required: old value 0 is returned in that cycle (bypass off), or 0x55 with `REG_WRITE_BYPASS_EN` defined; 0x55 is returned on the next cycle either way.
